// File: rtl/riscv_writeback_unit.sv
// Writeback stage: aligns and extends load data, produces one register-file
// write per retiring instruction and counts fault-free retirements.
module riscv_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_res,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic [4:0]       reg_wr,
  output logic [XLEN-1:0]  reg_wr_data,
  output logic             load_fault,
  output logic [CNT_W-1:0] retired
);
  localparam int OFF_W   = (XLEN == 64) ? 3 : 2;
  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [4:0]       wr_q, wr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [OFF_W-1:0] in_off;
  logic             load_legal, load_aligned;
  logic [XLEN-1:0]  shifted, load_val;
  logic             do_wr, retire;
  logic [4:0]       wr_idx;
  logic [XLEN-1:0]  wr_val;

  assign in_off  = in_res[OFF_W-1:0];
  assign shifted = mem_rsp_data >> {off_q, 3'b000};

  always_comb begin
    load_legal = 1'b0;
    case (in_funct3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: load_legal = 1'b1;
      3'd3, 3'd6:                   load_legal = IS_RV64;
      default:                      load_legal = 1'b0;
    endcase
    // funct3[1:0] encodes the access size for every legal load
    case (in_funct3[1:0])
      2'd0:    load_aligned = 1'b1;
      2'd1:    load_aligned = ~in_off[0];
      2'd2:    load_aligned = (in_off[1:0] == 2'b00);
      default: load_aligned = (in_off == '0);
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'd0:    load_val = XLEN'($signed(shifted[7:0]));
      3'd1:    load_val = XLEN'($signed(shifted[15:0]));
      3'd2:    load_val = XLEN'($signed(shifted[31:0]));
      3'd4:    load_val = XLEN'(shifted[7:0]);
      3'd5:    load_val = XLEN'(shifted[15:0]);
      3'd6:    load_val = XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    off_d     = off_q;
    wr_d      = '0;
    data_d    = data_q;
    fault_d   = 1'b0;
    retired_d = retired_q;
    do_wr     = 1'b0;
    retire    = 1'b0;
    wr_idx    = '0;
    wr_val    = '0;
    in_ready  = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_idx = in_rd;
          case (in_opcode)
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_AUIPC: begin
              do_wr  = 1'b1;
              wr_val = in_res;
              retire = 1'b1;
            end
            OPC_LUI: begin
              do_wr  = 1'b1;
              wr_val = in_imm;
              retire = 1'b1;
            end
            OPC_OP_32, OPC_OP_IMM_32: begin
              retire = 1'b1;
              if (IS_RV64) begin
                do_wr  = 1'b1;
                wr_val = XLEN'($signed(in_res[31:0]));
              end
            end
            OPC_LOAD: begin
              if (load_legal && load_aligned) begin
                state_d  = WAIT_LOAD;
                funct3_d = in_funct3;
                rd_d     = in_rd;
                off_d    = in_off;
              end else begin
                fault_d = 1'b1;
              end
            end
            default: retire = 1'b1;
          endcase
        end
      end
      WAIT_LOAD: begin
        if (mem_rsp_valid) begin
          do_wr   = 1'b1;
          wr_idx  = rd_q;
          wr_val  = load_val;
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // x0 writes are suppressed and leave the data register untouched
    if (do_wr && (wr_idx != 5'd0)) begin
      wr_d   = wr_idx;
      data_d = wr_val;
    end
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      rd_q      <= '0;
      off_q     <= '0;
      wr_q      <= '0;
      data_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign reg_wr      = wr_q;
  assign reg_wr_data = data_q;
  assign load_fault  = fault_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_riscv_writeback_unit.sv
// Scoreboard bench for riscv_writeback_unit: one RV32 and one RV64 instance
// share stimulus; sel64 steers valid strobes to the instance under test.
module tb_riscv_writeback_unit;
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        fault;
  } expT;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP32  = 7'b0111011;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        inValid;
  logic [6:0]  inOpcode;
  logic [2:0]  inFunct3;
  logic [4:0]  inRd;
  logic [63:0] inImm;
  logic [63:0] inRes;
  logic        memRspValid;
  logic [63:0] memRspData;

  logic        inReady32, inReady64;
  logic [4:0]  regWr32, regWr64;
  logic [31:0] regWrData32;
  logic [63:0] regWrData64;
  logic        loadFault32, loadFault64;
  logic [31:0] retired32, retired64;

  int  checks = 0;
  int  errors = 0;
  expT exp32[$];
  expT exp64[$];
  expT got32, got64;

  always #5 clk = ~clk;

  riscv_writeback_unit #(.XLEN(32), .CNT_W(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & ~sel64), .in_ready(inReady32),
    .in_opcode(inOpcode), .in_funct3(inFunct3), .in_rd(inRd),
    .in_imm(inImm[31:0]), .in_res(inRes[31:0]),
    .mem_rsp_valid(memRspValid & ~sel64), .mem_rsp_data(memRspData[31:0]),
    .reg_wr(regWr32), .reg_wr_data(regWrData32),
    .load_fault(loadFault32), .retired(retired32)
  );

  riscv_writeback_unit #(.XLEN(64), .CNT_W(32)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(inValid & sel64), .in_ready(inReady64),
    .in_opcode(inOpcode), .in_funct3(inFunct3), .in_rd(inRd),
    .in_imm(inImm), .in_res(inRes),
    .mem_rsp_valid(memRspValid & sel64), .mem_rsp_data(memRspData),
    .reg_wr(regWr64), .reg_wr_data(regWrData64),
    .load_fault(loadFault64), .retired(retired64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushExp(input bit is64, input logic [4:0] rd, input logic [63:0] data, input logic fault);
    expT e;
    e.rd = rd; e.data = data; e.fault = fault;
    if (is64) exp64.push_back(e);
    else exp32.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one instruction for one cycle; the cycle after acceptance is checked directly
  task automatic applyStimulus(input bit is64, input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [63:0] imm, input logic [63:0] res,
                               input logic [4:0] expRd, input logic [63:0] expData, input logic expFault);
    sel64 = is64; inValid = 1'b1; inOpcode = op; inFunct3 = f3;
    inRd = rd; inImm = imm; inRes = res;
    if (expRd != 5'd0 || expFault) pushExp(is64, expRd, expData, expFault);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("issueWrIdx", is64 ? regWr64 : regWr32, expRd);
    checkOutput("issueFault", is64 ? loadFault64 : loadFault32, expFault);
  endtask

  task automatic memRespond(input bit is64, input logic [63:0] data, input logic [4:0] expRd, input logic [63:0] expData);
    sel64 = is64; memRspValid = 1'b1; memRspData = data;
    if (expRd != 5'd0) pushExp(is64, expRd, expData, 1'b0);
    @(posedge clk);
    #1;
    memRspValid = 1'b0;
    checkOutput("rspWrIdx", is64 ? regWr64 : regWr32, expRd);
    checkOutput("rspReady", is64 ? inReady64 : inReady32, 1'b1);
  endtask

  always @(negedge clk) begin
    if (regWr32 != 5'd0 || loadFault32) begin
      if (exp32.size() == 0) begin
        checkOutput("spurious32", {58'd0, loadFault32, regWr32}, 64'd0);
      end else begin
        got32 = exp32.pop_front();
        checkOutput("sbRd32", regWr32, got32.rd);
        checkOutput("sbFault32", loadFault32, got32.fault);
        if (got32.rd != 5'd0) checkOutput("sbData32", {32'd0, regWrData32}, got32.data);
      end
    end
  end

  always @(negedge clk) begin
    if (regWr64 != 5'd0 || loadFault64) begin
      if (exp64.size() == 0) begin
        checkOutput("spurious64", {58'd0, loadFault64, regWr64}, 64'd0);
      end else begin
        got64 = exp64.pop_front();
        checkOutput("sbRd64", regWr64, got64.rd);
        checkOutput("sbFault64", loadFault64, got64.fault);
        if (got64.rd != 5'd0) checkOutput("sbData64", regWrData64, got64.data);
      end
    end
  end

  initial begin
    rst = 1'b1; sel64 = 1'b0; inValid = 1'b0; inOpcode = '0; inFunct3 = '0;
    inRd = '0; inImm = '0; inRes = '0; memRspValid = 1'b0; memRspData = '0;
    idle(2);
    checkOutput("rstReady32", inReady32, 1'b1);
    checkOutput("rstWr32", regWr32, 5'd0);
    checkOutput("rstData32", regWrData32, 32'd0);
    checkOutput("rstFault32", loadFault32, 1'b0);
    checkOutput("rstRetired32", retired32, 32'd0);
    checkOutput("rstReady64", inReady64, 1'b1);
    checkOutput("rstWr64", regWr64, 5'd0);
    checkOutput("rstData64", regWrData64, 64'd0);
    checkOutput("rstFault64", loadFault64, 1'b0);
    checkOutput("rstRetired64", retired64, 32'd0);
    rst = 1'b0;
    idle(1);

    // RV32: ADD, write visible for exactly one cycle
    applyStimulus(0, OP_OP, 3'd0, 5'd5, 64'd0, 64'h1234_5678, 5'd5, 64'h1234_5678, 1'b0);
    idle(1);
    checkOutput("addWrClear", regWr32, 5'd0);
    checkOutput("addRetired", retired32, 32'd1);

    // RV32: LB from offset 3 with a three-cycle memory wait
    applyStimulus(0, OP_LOAD, 3'd0, 5'd7, 64'd0, 64'h1003, 5'd0, 64'd0, 1'b0);
    checkOutput("lbReadyN1", inReady32, 1'b0);
    idle(1);
    checkOutput("lbReadyN2", inReady32, 1'b0);
    idle(1);
    memRespond(0, 64'h80FF_0000, 5'd7, 64'hFFFF_FF80);
    checkOutput("lbRetired", retired32, 32'd2);

    // RV32: LHU at minimum latency
    applyStimulus(0, OP_LOAD, 3'd5, 5'd9, 64'd0, 64'h1002, 5'd0, 64'd0, 1'b0);
    memRespond(0, 64'hBEEF_0000, 5'd9, 64'h0000_BEEF);

    // RV32: misaligned LH faults without a wait state; a stray response is dropped
    applyStimulus(0, OP_LOAD, 3'd1, 5'd10, 64'd0, 64'h1001, 5'd0, 64'd0, 1'b1);
    checkOutput("lhFaultReady", inReady32, 1'b1);
    checkOutput("lhFaultRetired", retired32, 32'd3);
    sel64 = 1'b0; memRspValid = 1'b1; memRspData = 64'hFFFF_FFFF;
    idle(1);
    memRspValid = 1'b0;
    checkOutput("idleRspFault", loadFault32, 1'b0);
    checkOutput("idleRspWr", regWr32, 5'd0);

    // RV32: LUI to x0 then a store, back to back
    applyStimulus(0, OP_LUI, 3'd0, 5'd0, 64'h1234_5000, 64'd0, 5'd0, 64'd0, 1'b0);
    checkOutput("luiReady", inReady32, 1'b1);
    applyStimulus(0, OP_STORE, 3'd2, 5'd5, 64'd0, 64'h2000, 5'd0, 64'd0, 1'b0);
    checkOutput("b2bRetired", retired32, 32'd5);

    // RV32: OP-32 is "other"; funct3=3 is an illegal load
    applyStimulus(0, OP_OP32, 3'd0, 5'd6, 64'd0, 64'h8000_0000, 5'd0, 64'd0, 1'b0);
    applyStimulus(0, OP_LOAD, 3'd3, 5'd4, 64'd0, 64'h2000, 5'd0, 64'd0, 1'b1);
    checkOutput("ld32Retired", retired32, 32'd6);

    // RV32: reset abandons a pending load
    applyStimulus(0, OP_LOAD, 3'd2, 5'd8, 64'd0, 64'h3000, 5'd0, 64'd0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("rstWaitReady", inReady32, 1'b1);
    checkOutput("rstWaitRetired", retired32, 32'd0);
    sel64 = 1'b0; memRspValid = 1'b1; memRspData = 64'h5555_AAAA;
    idle(1);
    memRspValid = 1'b0;
    checkOutput("rstDropWr", regWr32, 5'd0);
    checkOutput("rstDropData", regWrData32, 32'd0);
    applyStimulus(0, OP_OP, 3'd0, 5'd3, 64'd0, 64'hCAFE, 5'd3, 64'hCAFE, 1'b0);
    checkOutput("postRstRetired", retired32, 32'd1);

    // RV64 loads and OP-32 sign extension
    applyStimulus(1, OP_LOAD, 3'd6, 5'd11, 64'd0, 64'h4004, 5'd0, 64'd0, 1'b0);
    idle(1);
    memRspond64: begin
      memRespond(1, 64'h8765_4321_0000_0000, 5'd11, 64'h0000_0000_8765_4321);
    end
    applyStimulus(1, OP_OP32, 3'd0, 5'd12, 64'd0, 64'h0000_0000_8000_0000, 5'd12, 64'hFFFF_FFFF_8000_0000, 1'b0);
    applyStimulus(1, OP_LOAD, 3'd3, 5'd13, 64'd0, 64'h5000, 5'd0, 64'd0, 1'b0);
    memRespond(1, 64'h0123_4567_89AB_CDEF, 5'd13, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1, OP_LOAD, 3'd2, 5'd14, 64'd0, 64'h6004, 5'd0, 64'd0, 1'b0);
    memRespond(1, 64'h8000_0000_0000_0000, 5'd14, 64'hFFFF_FFFF_8000_0000);
    checkOutput("rv64Retired", retired64, 32'd4);
    applyStimulus(1, OP_LOAD, 3'd3, 5'd15, 64'd0, 64'h5004, 5'd0, 64'd0, 1'b1);
    checkOutput("ldMisReady", inReady64, 1'b1);
    applyStimulus(1, OP_LOAD, 3'd0, 5'd15, 64'd0, 64'h7007, 5'd0, 64'd0, 1'b0);
    memRespond(1, 64'h7F00_0000_0000_0000, 5'd15, 64'h0000_0000_0000_007F);
    applyStimulus(1, OP_LOAD, 3'd1, 5'd16, 64'd0, 64'h7006, 5'd0, 64'd0, 1'b0);
    memRespond(1, 64'h8001_0000_0000_0000, 5'd16, 64'hFFFF_FFFF_FFFF_8001);
    checkOutput("rv64RetiredEnd", retired64, 32'd6);

    idle(3);
    checkOutput("drain32", exp32.size(), 64'd0);
    checkOutput("drain64", exp64.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
